// File: rtl/icache_way_bank.sv
// Set-associative instruction-cache data/valid bank with a beat-wise line refill FSM.
// Optional feature: define ICACHE_FLUSH_SWEEP_EN to enable flush_i as a one-set-per-cycle valid sweep.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no refill in progress; accepts refill_start_i (and flush_i)
// S_FILL  | collecting BEATS refill beats into the fill buffer
// S_WRITE | one cycle: fill buffer written to the array, line marked valid
module icache_way_bank #(
    parameter int WAYS       = 4,
    parameter int SET_WIDTH  = 128,
    parameter int DEPTH      = 256,
    parameter int BEAT_WIDTH = 64,
    localparam int BEATS     = SET_WIDTH / BEAT_WIDTH,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rd_req_i,
    input  logic [ADDR_W-1:0]         rd_addr_i,
    output logic                      rd_ready_o,
    output logic                      rd_valid_o,
    output logic [WAYS*SET_WIDTH-1:0] rd_data_o,
    output logic [WAYS-1:0]           rd_line_valid_o,
    input  logic                      refill_start_i,
    input  logic [ADDR_W-1:0]         refill_addr_i,
    input  logic [WAY_W-1:0]          refill_way_i,
    input  logic                      beat_valid_i,
    input  logic [BEAT_WIDTH-1:0]     beat_data_i,
    output logic                      refill_busy_o,
    output logic                      refill_done_o,
    input  logic                      flush_i,
    output logic                      flush_busy_o
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [WAY_W-1:0]       way_q;
    logic [SET_WIDTH-1:0]   fill_buf_q;
    logic                   refill_busy_q;
    logic                   refill_done_q;

    logic [WAYS-1:0]        valid_q [DEPTH];
    logic [SET_WIDTH-1:0]   mem_q   [WAYS][DEPTH];

    logic                   flush_busy_q;
    logic                   flush_go;
    logic                   refill_go;
    logic                   rd_accept;

`ifdef ICACHE_FLUSH_SWEEP_EN
    logic [ADDR_W-1:0]      flush_idx_q;

    assign flush_go = flush_i && (state_q == S_IDLE) && !flush_busy_q;
`else
    logic                   unused_flush;

    assign unused_flush = flush_i;
    assign flush_go     = 1'b0;
    assign flush_busy_q = 1'b0;
`endif

    // Flush wins over a simultaneous refill start; no refill may start mid-sweep.
    assign refill_go  = (state_q == S_IDLE) && refill_start_i && !flush_go && !flush_busy_q;
    assign rd_ready_o = (state_q != S_WRITE) && !flush_busy_q;
    assign rd_accept  = rd_req_i && rd_ready_o;

    assign refill_busy_o = refill_busy_q;
    assign refill_done_o = refill_done_q;
    assign flush_busy_o  = flush_busy_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            refill_busy_q <= 1'b0;
            refill_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= '0;
            end
        end else begin
            refill_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (refill_go) begin
                        addr_q                                <= refill_addr_i;
                        way_q                                 <= refill_way_i;
                        valid_q[refill_addr_i][refill_way_i] <= 1'b0;
                        cnt_q                                 <= '0;
                        refill_busy_q                         <= 1'b1;
                        state_q                               <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (beat_valid_i) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (cnt_q == CNT_W'(b)) begin
                                fill_buf_q[b*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data_i;
                            end
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            refill_done_q <= 1'b1;
                            state_q       <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    valid_q[addr_q][way_q] <= 1'b1;
                    refill_busy_q          <= 1'b0;
                    state_q                <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
`ifdef ICACHE_FLUSH_SWEEP_EN
            if (flush_busy_q) begin
                valid_q[flush_idx_q] <= '0;
            end
`endif
        end
    end

`ifdef ICACHE_FLUSH_SWEEP_EN
    // Sweep clears set k in the k-th busy cycle, so busy lasts exactly DEPTH cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_busy_q <= 1'b0;
            flush_idx_q  <= '0;
        end else if (flush_busy_q) begin
            flush_idx_q <= flush_idx_q + 1'b1;
            if (flush_idx_q == ADDR_W'(DEPTH - 1)) begin
                flush_busy_q <= 1'b0;
            end
        end else if (flush_go) begin
            flush_busy_q <= 1'b1;
            flush_idx_q  <= '0;
        end
    end
`endif

    // Line storage is deliberately not reset; a reset mid-refill must not write it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_q == S_WRITE)) begin
            mem_q[way_q][addr_q] <= fill_buf_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_o      <= 1'b0;
            rd_data_o       <= '0;
            rd_line_valid_o <= '0;
        end else begin
            rd_valid_o <= rd_accept;
            if (rd_accept) begin
                rd_line_valid_o <= valid_q[rd_addr_i];
                for (int w = 0; w < WAYS; w++) begin
                    rd_data_o[w*SET_WIDTH +: SET_WIDTH] <= mem_q[w][rd_addr_i];
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_way_bank.sv
// Directed bench for icache_way_bank: reads, refills, read-during-fill, WRITE stall, reset abort, flush.
// Honours ICACHE_FLUSH_SWEEP_EN to select flush or flush-ignored expectations.
module tb_icache_way_bank;

    localparam int WAYS  = 4;
    localparam int SW    = 128;
    localparam int DEPTH = 256;
    localparam int BW    = 64;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              rd_req_i;
    logic [7:0]        rd_addr_i;
    logic              rd_ready_o;
    logic              rd_valid_o;
    logic [WAYS*SW-1:0] rd_data_o;
    logic [WAYS-1:0]   rd_line_valid_o;
    logic              refill_start_i;
    logic [7:0]        refill_addr_i;
    logic [1:0]        refill_way_i;
    logic              beat_valid_i;
    logic [BW-1:0]     beat_data_i;
    logic              refill_busy_o;
    logic              refill_done_o;
    logic              flush_i;
    logic              flush_busy_o;

    int checks = 0;
    int passes = 0;

    icache_way_bank #(
        .WAYS(WAYS), .SET_WIDTH(SW), .DEPTH(DEPTH), .BEAT_WIDTH(BW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_ready_o(rd_ready_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_line_valid_o(rd_line_valid_o),
        .refill_start_i(refill_start_i), .refill_addr_i(refill_addr_i), .refill_way_i(refill_way_i),
        .beat_valid_i(beat_valid_i), .beat_data_i(beat_data_i),
        .refill_busy_o(refill_busy_o), .refill_done_o(refill_done_o),
        .flush_i(flush_i), .flush_busy_o(flush_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        rst_i = 1'b1; rd_req_i = 1'b0; rd_addr_i = '0;
        refill_start_i = 1'b0; refill_addr_i = '0; refill_way_i = '0;
        beat_valid_i = 1'b0; beat_data_i = '0; flush_i = 1'b0;
        step(); step();
        rst_i = 1'b0;

        check("rst_rd_valid", rd_valid_o, 0);
        check("rst_rd_data", rd_data_o[127:0], 0);
        check("rst_rd_data_w3", rd_data_o[3*SW +: SW], 0);
        check("rst_line_valid", rd_line_valid_o, 0);
        check("rst_refill_busy", refill_busy_o, 0);
        check("rst_refill_done", refill_done_o, 0);
        check("rst_flush_busy", flush_busy_o, 0);
        check("rst_rd_ready", rd_ready_o, 1);

        // Read set 5 after reset
        rd_req_i = 1'b1; rd_addr_i = 8'd5;
        step();
        rd_req_i = 1'b0;
        check("rd5_valid", rd_valid_o, 1);
        check("rd5_line_valid", rd_line_valid_o, 4'b0000);
        step();
        check("rd_idle_valid", rd_valid_o, 0);

        // Refill set 5 way 2 with A, B
        refill_start_i = 1'b1; refill_addr_i = 8'd5; refill_way_i = 2'd2;
        step();
        refill_start_i = 1'b0;
        check("fill_busy", refill_busy_o, 1);
        check("fill_done_low", refill_done_o, 0);
        beat_valid_i = 1'b1; beat_data_i = 64'hA;
        step();
        beat_data_i = 64'hB;
        step();
        beat_valid_i = 1'b0;
        check("write_done", refill_done_o, 1);
        check("write_ready", rd_ready_o, 0);
        step();
        check("done_one_cycle", refill_done_o, 0);
        check("busy_clear", refill_busy_o, 0);
        rd_req_i = 1'b1; rd_addr_i = 8'd5;
        step();
        rd_req_i = 1'b0;
        check("rd5b_valid", rd_valid_o, 1);
        check("rd5b_line_valid", rd_line_valid_o, 4'b0100);
        check("rd5b_way2", rd_data_o[2*SW +: SW], {64'hB, 64'hA});

        // Read held high across WRITE of set 7 way 1
        refill_start_i = 1'b1; refill_addr_i = 8'd7; refill_way_i = 2'd1;
        rd_req_i = 1'b1; rd_addr_i = 8'd7;
        step();
        refill_start_i = 1'b0;
        check("hold_e1_valid", rd_valid_o, 1);
        check("hold_e1_lv", rd_line_valid_o, 4'b0000);
        beat_valid_i = 1'b1; beat_data_i = 64'hC;
        step();
        check("hold_e2_valid", rd_valid_o, 1);
        beat_data_i = 64'hD;
        step();
        beat_valid_i = 1'b0;
        check("hold_write_ready", rd_ready_o, 0);
        check("hold_e3_valid", rd_valid_o, 1);
        step();
        check("hold_no_resp", rd_valid_o, 0);
        check("hold_ready_back", rd_ready_o, 1);
        step();
        rd_req_i = 1'b0;
        check("hold_after_valid", rd_valid_o, 1);
        check("hold_after_lv", rd_line_valid_o, 4'b0010);
        check("hold_after_way1", rd_data_o[1*SW +: SW], {64'hD, 64'hC});

        // Read set 5 during refill of set 5 way 2 (E, F), also ignoring a start mid-FILL
        refill_start_i = 1'b1; refill_addr_i = 8'd5; refill_way_i = 2'd2;
        step();
        refill_addr_i = 8'd9; refill_way_i = 2'd0;
        beat_valid_i = 1'b1; beat_data_i = 64'hE;
        step();
        refill_start_i = 1'b0;
        beat_valid_i = 1'b0;
        rd_req_i = 1'b1; rd_addr_i = 8'd5;
        step();
        rd_req_i = 1'b0;
        check("rdfill_valid", rd_valid_o, 1);
        check("rdfill_lv", rd_line_valid_o, 4'b0000);
        check("rdfill_old_data", rd_data_o[2*SW +: SW], {64'hB, 64'hA});
        beat_valid_i = 1'b1; beat_data_i = 64'hF;
        step();
        beat_valid_i = 1'b0;
        check("refill2_done", refill_done_o, 1);
        step();
        rd_req_i = 1'b1; rd_addr_i = 8'd5;
        step();
        rd_req_i = 1'b0;
        check("refill2_lv", rd_line_valid_o, 4'b0100);
        check("refill2_data", rd_data_o[2*SW +: SW], {64'hF, 64'hE});
        rd_req_i = 1'b1; rd_addr_i = 8'd9;
        step();
        rd_req_i = 1'b0;
        check("ignored_start_lv", rd_line_valid_o, 4'b0000);

        // Reset after first beat of FILL aborts without writing
        refill_start_i = 1'b1; refill_addr_i = 8'd5; refill_way_i = 2'd2;
        step();
        refill_start_i = 1'b0;
        beat_valid_i = 1'b1; beat_data_i = 64'h11;
        step();
        beat_valid_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("abort_busy", refill_busy_o, 0);
        check("abort_done", refill_done_o, 0);
        beat_valid_i = 1'b1; beat_data_i = 64'h22;
        step();
        beat_valid_i = 1'b0;
        check("abort_idle_ignores_beat", refill_done_o, 0);
        rd_req_i = 1'b1; rd_addr_i = 8'd5;
        step();
        rd_req_i = 1'b0;
        check("abort_lv", rd_line_valid_o, 4'b0000);
        check("abort_old_data", rd_data_o[2*SW +: SW], {64'hF, 64'hE});

        // Refill set 9 way 3 so there is a valid line for the flush case
        refill_start_i = 1'b1; refill_addr_i = 8'd9; refill_way_i = 2'd3;
        step();
        refill_start_i = 1'b0;
        beat_valid_i = 1'b1; beat_data_i = 64'h33;
        step();
        beat_data_i = 64'h44;
        step();
        beat_valid_i = 1'b0;
        step();
        rd_req_i = 1'b1; rd_addr_i = 8'd9;
        step();
        rd_req_i = 1'b0;
        check("set9_lv", rd_line_valid_o, 4'b1000);

        // flush_i together with refill_start_i
        flush_i = 1'b1; refill_start_i = 1'b1; refill_addr_i = 8'd5; refill_way_i = 2'd0;
        step();
        flush_i = 1'b0; refill_start_i = 1'b0;
`ifdef ICACHE_FLUSH_SWEEP_EN
        check("flush_busy_on", flush_busy_o, 1);
        check("flush_no_refill", refill_busy_o, 0);
        check("flush_ready_low", rd_ready_o, 0);
        n = 0;
        while (flush_busy_o && n < 400) begin
            n++;
            refill_start_i = 1'b1;
            step();
        end
        refill_start_i = 1'b0;
        check("flush_cycles", n, DEPTH);
        check("flush_no_refill_end", refill_busy_o, 0);
        rd_req_i = 1'b1; rd_addr_i = 8'd9;
        step();
        rd_addr_i = 8'd7;
        check("flush_set9_lv", rd_line_valid_o, 4'b0000);
        step();
        rd_req_i = 1'b0;
        check("flush_set7_lv", rd_line_valid_o, 4'b0000);
`else
        n = 0;
        check("noflush_busy", flush_busy_o, 0);
        check("noflush_refill", refill_busy_o, 1);
        beat_valid_i = 1'b1; beat_data_i = 64'h55;
        step();
        beat_data_i = 64'h66;
        step();
        beat_valid_i = 1'b0;
        check("noflush_done", refill_done_o, 1);
        step();
        rd_req_i = 1'b1; rd_addr_i = 8'd9;
        step();
        rd_req_i = 1'b0;
        check("noflush_set9_lv", rd_line_valid_o, 4'b1000);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/icache_way_bank.md
ICACHE_WAY_BANK -- requirements
Module: icache_way_bank

Interface
REQ-001 The block SHALL have parameter WAYS, default 4, the number of ways in the set.
REQ-002 The block SHALL have parameter SET_WIDTH, default 128, the line width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 256, the number of sets.
REQ-004 The block SHALL have parameter BEAT_WIDTH, default 64, the refill beat width; SET_WIDTH is a multiple of BEAT_WIDTH; BEATS=SET_WIDTH/BEAT_WIDTH; ADDR_W=clog2(DEPTH); WAY_W=clog2(WAYS).
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have read-request ports: rd_req_i (input, 1, read request), rd_addr_i (input, ADDR_W, set index) and rd_ready_o (output, 1, read accepted this cycle).
REQ-008 The block SHALL have read-response ports: rd_valid_o (output, 1, response valid), rd_data_o (output, WAYS*SET_WIDTH, all ways; way w at [w*SET_WIDTH +: SET_WIDTH]) and rd_line_valid_o (output, WAYS, per-way line valid bits).
REQ-009 The block SHALL have refill-request ports: refill_start_i (input, 1, begin a line refill), refill_addr_i (input, ADDR_W, target set) and refill_way_i (input, WAY_W, target way).
REQ-010 The block SHALL have refill-beat ports: beat_valid_i (input, 1, beat present) and beat_data_i (input, BEAT_WIDTH, beat payload).
REQ-011 The block SHALL have refill-status ports: refill_busy_o (output, 1, FSM not IDLE) and refill_done_o (output, 1, one-cycle line-written pulse).
REQ-012 The block SHALL have flush ports: flush_i (input, 1, invalidate all lines) and flush_busy_o (output, 1, flush sweep active).

Function
REQ-013 The refill FSM SHALL have states IDLE, FILL and WRITE.
REQ-014 In IDLE, when refill_start_i=1 and flush_i=0, the block SHALL latch refill_addr_i and refill_way_i, clear that line's valid bit, zero the beat counter and enter FILL.
REQ-015 In FILL, each cycle with beat_valid_i=1 SHALL store beat_data_i at fill-buffer bits [cnt*BEAT_WIDTH +: BEAT_WIDTH] and increment cnt.
REQ-016 The beat with cnt=BEATS-1 SHALL move the FSM to WRITE.
REQ-017 In WRITE, for exactly one cycle, the block SHALL write the fill buffer to the latched way/set, set its valid bit, pulse refill_done_o=1 and return to IDLE.
REQ-018 refill_start_i outside IDLE, and beat_valid_i in IDLE or WRITE, SHALL be ignored.
REQ-019 rd_ready_o SHALL be 0 in WRITE and while flush_busy_o=1, and 1 otherwise.
REQ-020 A read SHALL be accepted when rd_req_i=1 and rd_ready_o=1.
REQ-021 The cycle after an accepted read, rd_valid_o SHALL be 1, with rd_data_o and rd_line_valid_o showing the set state as of the acceptance cycle (latency 1).
REQ-022 When no read was accepted in the previous cycle, rd_valid_o SHALL be 0 and rd_data_o SHALL hold its last value.
REQ-023 A read of the set/way being filled during FILL SHALL return the old data with its valid bit 0.
REQ-024 A read accepted the cycle after WRITE SHALL return the new line with its valid bit 1.

Reset
REQ-025 While rst_i=1 at a clock edge, the block SHALL clear all WAYS*DEPTH valid bits, set the FSM to IDLE and zero cnt and the flush index.
REQ-026 After reset, rd_valid_o, rd_data_o, rd_line_valid_o, refill_busy_o, refill_done_o and flush_busy_o SHALL all be 0.
REQ-027 Line data storage SHALL NOT be reset.
REQ-028 Reset during FILL or WRITE SHALL abort the refill with no array write.

Configuration
REQ-029 With macro ICACHE_FLUSH_SWEEP_EN defined, flush_i=1 in IDLE with no sweep active SHALL start a sweep that clears all ways' valid bits at index k in cycle k, for k=0..DEPTH-1.
REQ-030 With ICACHE_FLUSH_SWEEP_EN defined, flush_busy_o SHALL be 1 for exactly DEPTH cycles, refill_start_i SHALL be ignored during the sweep, flush_i SHALL win over a simultaneous refill_start_i, and flush_i outside IDLE SHALL be ignored.
REQ-031 Without ICACHE_FLUSH_SWEEP_EN, flush_i SHALL be ignored, flush_busy_o SHALL be tied to 0, and valid bits SHALL be cleared only by reset and by refill start.

Verification
REQ-032 Bench SHALL cover: reset, then read set 5 -> next cycle rd_valid_o=1, rd_line_valid_o=4'b0000.
REQ-033 Bench SHALL cover: refill set 5 way 2 with beats 64'hA, 64'hB -> refill_done_o pulses 1 cycle; read set 5 -> way 2 data = {64'hB,64'hA}, rd_line_valid_o=4'b0100.
REQ-034 Bench SHALL cover: read set 5 during FILL of set 5 way 2, after a prior valid fill -> old data returned, rd_line_valid_o[2]=0.
REQ-035 Bench SHALL cover: rd_req_i held high across WRITE -> rd_ready_o=0 for exactly that cycle; no response is produced for it.
REQ-036 Bench SHALL cover: rst_i asserted after the first beat of FILL -> FSM returns to IDLE and the target line stays invalid with old data.
REQ-037 Bench SHALL cover, with ICACHE_FLUSH_SWEEP_EN: flush_i and refill_start_i in the same cycle -> flush_busy_o=1 for 256 cycles, no refill, all valid bits 0 afterward.
